// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: arbiter state type, default widths and the byte-merge helper
`timescale 1ns/1ps
package dmem_arb_pkg;
  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} arb_state_e;
  localparam int DATA_W_DEF = 32;
  localparam int BE_W = DATA_W_DEF / 8;
  function automatic logic [7:0] merge_byte(input logic be, input logic [7:0] wd, input logic [7:0] q);
    return be ? wd : q;
  endfunction
endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// rr_pick2: two-way round-robin picker; last=1 means port 1 won last, so port 0 has priority
`timescale 1ns/1ps
module rr_pick2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);
  assign gnt_o[0] = req_i[0] & (~req_i[1] | last_i);
  assign gnt_o[1] = req_i[1] & (~req_i[0] | ~last_i);
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data RAM between the CPU LSU (port 0) and the loader (port 1)
`timescale 1ns/1ps
module dmem_arbiter import dmem_arb_pkg::*; #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                m0_req,
  input  logic                m0_we,
  input  logic                m0_lock,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_be,
  output logic                m0_gnt,
  output logic                m0_rvalid,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_req,
  input  logic                m1_we,
  input  logic                m1_lock,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_be,
  output logic                m1_gnt,
  output logic                m1_rvalid,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_d,
  output logic                ram_we,
  input  logic [DATA_W-1:0]   ram_q
);
  localparam int BW = DATA_W / 8;
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MB = CW'(MAX_BURST);
  arb_state_e state_q, state_d;
  logic last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] pick, gnt;
  logic pick_last, below, keep, win, lk, sel_we;
  logic [BW-1:0] sel_be;
  logic [DATA_W-1:0] sel_wd, rd0_q, rd1_q;
  logic rv0_q, rv1_q;
  // a lock owner counts as "last" so the waiting port wins when the owner lets go
  assign pick_last = (state_q == LOCK0) ? 1'b0 : (state_q == LOCK1) ? 1'b1 : last_q;
  rr_pick2 u_pick (.req_i({m1_req, m0_req}), .last_i(pick_last), .gnt_o(pick));
  assign below = cnt_q < MB;
  assign keep = (state_q == LOCK0 && m0_req && (below || !m1_req)) ||
                (state_q == LOCK1 && m1_req && (below || !m0_req));
  assign gnt = !rst_n ? 2'b00 : keep ? ((state_q == LOCK1) ? 2'b10 : 2'b01) : pick;
  assign win = gnt[1];
  assign lk = win ? m1_lock : m0_lock;
  always_comb begin
    state_d = IDLE;
    cnt_d = '0;
    last_d = last_q;
    if (|gnt) begin
      last_d = win;
      state_d = !lk ? IDLE : keep ? state_q : win ? LOCK1 : LOCK0;
      cnt_d = keep ? (below ? cnt_q + 1'b1 : MB) : lk ? CW'(1) : '0;
    end
  end
  assign sel_we = win ? m1_we : m0_we;
  assign sel_be = win ? m1_be : m0_be;
  assign sel_wd = win ? m1_wdata : m0_wdata;
  assign ram_addr = win ? m1_addr : m0_addr;
  assign ram_we = (|gnt) & sel_we & (|sel_be);
  // partial writes merge against the combinational read of the same word
  for (genvar i = 0; i < BW; i++) begin : g_merge
    assign ram_d[8*i +: 8] = merge_byte(sel_be[i], sel_wd[8*i +: 8], ram_q[8*i +: 8]);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q <= 1'b1;
      cnt_q <= '0;
      rv0_q <= 1'b0;
      rv1_q <= 1'b0;
      rd0_q <= '0;
      rd1_q <= '0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
      rv0_q <= gnt[0] & ~m0_we;
      rv1_q <= gnt[1] & ~m1_we;
      if (gnt[0] & ~m0_we) rd0_q <= ram_q;
      if (gnt[1] & ~m1_we) rd1_q <= ram_q;
    end
  end
  assign m0_gnt = gnt[0];
  assign m1_gnt = gnt[1];
  assign m0_rvalid = rv0_q;
  assign m1_rvalid = rv1_q;
  assign m0_rdata = rd0_q;
  assign m1_rdata = rd1_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of arbitration, locked bursts, byte writes and reset
`timescale 1ns/1ps
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0;
  logic m0_req = 0, m0_we = 0, m0_lock = 0, m1_req = 0, m1_we = 0, m1_lock = 0;
  logic [9:0] m0_addr = '0, m1_addr = '0, ram_addr;
  logic [31:0] m0_wdata = '0, m1_wdata = '0, m0_rdata, m1_rdata, ram_d, ram_q;
  logic [BE_W-1:0] m0_be = '0, m1_be = '0;
  logic m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, ram_we;
  logic [31:0] mem [0:1023];
  int errors = 0, checks = 0;

  always #5 clk = ~clk;
  assign ram_q = mem[ram_addr];
  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_d;

  dmem_arbiter #(.ADDR_W(10), .DATA_W(32), .MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_addr(ram_addr), .ram_d(ram_d), .ram_we(ram_we), .ram_q(ram_q));

  task automatic clear_inputs();
    m0_req = 0; m0_we = 0; m0_lock = 0; m0_be = '0;
    m1_req = 0; m1_we = 0; m1_lock = 0; m1_be = '0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    clear_inputs();
    @(posedge clk);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    m0_req = 1; m0_we = 1; m0_be = 4'hF; m1_req = 1;
    #1;
    checks++; if (m0_gnt !== 1'b0) begin errors++; $display("FAIL rst_m0_gnt got=%b exp=0", m0_gnt); end
    checks++; if (m1_gnt !== 1'b0) begin errors++; $display("FAIL rst_m1_gnt got=%b exp=0", m1_gnt); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL rst_ram_we got=%b exp=0", ram_we); end
    checks++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin errors++; $display("FAIL rst_rvalid got=%b exp=00", {m0_rvalid, m1_rvalid}); end
    checks++; if (m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got=%h/%h exp=0/0", m0_rdata, m1_rdata); end
    do_reset();
  endtask

  task automatic test_read();
    m1_req = 1; m1_we = 1; m1_addr = 10'd5; m1_wdata = 32'hDEADBEEF; m1_be = 4'hF;
    @(negedge clk);
    checks++; if (m1_gnt !== 1'b1 || ram_we !== 1'b1) begin errors++; $display("FAIL seed_wr got gnt=%b we=%b exp 1/1", m1_gnt, ram_we); end
    @(posedge clk); #1;
    clear_inputs();
    checks++; if (m1_rvalid !== 1'b0) begin errors++; $display("FAIL wr_no_rvalid got=%b exp=0", m1_rvalid); end
    m0_req = 1; m0_addr = 10'd5;
    @(negedge clk);
    checks++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin errors++; $display("FAIL rd_gnt got=%b%b exp=01", m1_gnt, m0_gnt); end
    @(posedge clk); #1;
    clear_inputs();
    checks++; if (m0_rvalid !== 1'b1) begin errors++; $display("FAIL rd_rvalid got=%b exp=1", m0_rvalid); end
    checks++; if (m0_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_rdata got=%h exp=deadbeef", m0_rdata); end
    checks++; if (m1_rvalid !== 1'b0) begin errors++; $display("FAIL rd_m1_quiet got=%b exp=0", m1_rvalid); end
    @(posedge clk); #1;
    checks++; if (m0_rvalid !== 1'b0 || m0_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_hold got v=%b d=%h exp 0/deadbeef", m0_rvalid, m0_rdata); end
  endtask

  task automatic test_alternate();
    m1_req = 1; m1_we = 1; m1_addr = 10'd6; m1_wdata = 32'h12345678; m1_be = 4'hF;
    @(posedge clk); #1;
    do_reset();
    m0_req = 1; m0_addr = 10'd5; m1_req = 1; m1_addr = 10'd6;
    for (int i = 0; i < 4; i++) begin
      logic e0;
      e0 = (i % 2 == 0);
      @(negedge clk);
      checks++; if (m0_gnt !== e0 || m1_gnt !== !e0) begin errors++; $display("FAIL alt_gnt[%0d] got=%b%b exp=%b%b", i, m1_gnt, m0_gnt, !e0, e0); end
      @(posedge clk); #1;
      checks++; if (m0_rvalid !== e0 || m1_rvalid !== !e0) begin errors++; $display("FAIL alt_rvalid[%0d] got=%b%b exp=%b%b", i, m1_rvalid, m0_rvalid, !e0, e0); end
      checks++; if ((e0 ? m0_rdata : m1_rdata) !== (e0 ? 32'hDEADBEEF : 32'h12345678)) begin errors++; $display("FAIL alt_rdata[%0d] got=%h/%h", i, m0_rdata, m1_rdata); end
    end
    clear_inputs();
  endtask

  task automatic test_byte_write();
    m0_req = 1; m0_we = 1; m0_addr = 10'd3; m0_wdata = 32'hAABBCCDD; m0_be = 4'hF;
    @(negedge clk);
    checks++; if (ram_we !== 1'b1 || ram_d !== 32'hAABBCCDD) begin errors++; $display("FAIL bw_full got we=%b d=%h exp 1/aabbccdd", ram_we, ram_d); end
    @(posedge clk); #1;
    m0_wdata = 32'h00001122; m0_be = 4'b0011;
    @(negedge clk);
    checks++; if (ram_we !== 1'b1 || ram_d !== 32'hAABB1122) begin errors++; $display("FAIL bw_partial got we=%b d=%h exp 1/aabb1122", ram_we, ram_d); end
    @(posedge clk); #1;
    m0_wdata = 32'hFFFFFFFF; m0_be = 4'b0000;
    @(negedge clk);
    checks++; if (m0_gnt !== 1'b1 || ram_we !== 1'b0) begin errors++; $display("FAIL bw_be0 got gnt=%b we=%b exp 1/0", m0_gnt, ram_we); end
    @(posedge clk); #1;
    checks++; if (m0_rvalid !== 1'b0) begin errors++; $display("FAIL bw_no_rvalid got=%b exp=0", m0_rvalid); end
    m0_we = 0;
    @(posedge clk); #1;
    clear_inputs();
    checks++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hAABB1122) begin errors++; $display("FAIL bw_readback got v=%b d=%h exp 1/aabb1122", m0_rvalid, m0_rdata); end
  endtask

  task automatic test_burst();
    do_reset();
    m0_req = 1; m0_lock = 1; m0_addr = 10'd5; m1_addr = 10'd6;
    for (int i = 0; i < 7; i++) begin
      logic e0;
      e0 = (i != 4);
      m1_req = (i >= 1);
      @(negedge clk);
      checks++; if (m0_gnt !== e0 || m1_gnt !== !e0) begin errors++; $display("FAIL burst_gnt[%0d] got=%b%b exp=%b%b", i, m1_gnt, m0_gnt, !e0, e0); end
      @(posedge clk); #1;
    end
    clear_inputs();
  endtask

  task automatic test_lock_drop();
    do_reset();
    m1_req = 1; m1_lock = 1; m1_addr = 10'd6; m0_addr = 10'd5;
    for (int i = 0; i < 3; i++) begin
      m0_req = (i >= 1);
      m1_req = (i < 2);
      @(negedge clk);
      checks++; if (m1_gnt !== (i < 2) || m0_gnt !== (i == 2)) begin errors++; $display("FAIL drop_gnt[%0d] got=%b%b exp=%b%b", i, m1_gnt, m0_gnt, i < 2, i == 2); end
      if (i == 2) begin
        checks++; if (ram_addr !== 10'd5) begin errors++; $display("FAIL drop_addr got=%0d exp=5", ram_addr); end
      end
      @(posedge clk); #1;
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    m1_req = 1; m1_lock = 1; m1_addr = 10'd6; m0_addr = 10'd5;
    @(posedge clk); #1;
    m0_req = 1;
    @(posedge clk); #1;
    rst_n = 0;
    m0_we = 1; m0_be = 4'hF;
    #1;
    checks++; if (m1_rvalid !== 1'b0) begin errors++; $display("FAIL mid_rvalid got=%b exp=0", m1_rvalid); end
    checks++; if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin errors++; $display("FAIL mid_gnt got=%b%b exp=00", m1_gnt, m0_gnt); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL mid_ram_we got=%b exp=0", ram_we); end
    @(negedge clk);
    rst_n = 1; m0_we = 0; m0_be = '0;
    #1;
    checks++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin errors++; $display("FAIL mid_first_win got=%b%b exp=01", m1_gnt, m0_gnt); end
    @(posedge clk); #1;
    checks++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL mid_read got v=%b d=%h exp 1/deadbeef", m0_rvalid, m0_rdata); end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_read();
    test_alternate();
    test_byte_write();
    test_burst();
    test_lock_drop();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port, word-wide data RAM between two requesters.
  - Port 0 is the CPU load/store unit.
  - Port 1 is the debug/program loader.
- Provides round-robin arbitration with bounded locked bursts.
- Implements byte-enable writes as a same-cycle read-modify-write. This is possible because the RAM read is combinational and the RAM write is synchronous.
- Returns read data registered, one cycle after grant.
- Sits between the core/loader and the RAM; it is the only driver of the RAM address, data and write-enable pins.

Parameters:
- ADDR_W, 10, word address width; matches RAM depth 2^ADDR_W.
- DATA_W, 32, data width; must be a multiple of 8.
- MAX_BURST, 8, maximum consecutive grants to a locked owner while the other port is waiting; range 1..255.

Ports:
- clk  in  1  single clock, rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- m0_req  in  1  port 0 transfer request.
- m0_we  in  1  1 = write, 0 = read.
- m0_lock  in  1  request to keep ownership for the next transfer.
- m0_addr  in  ADDR_W  word address.
- m0_wdata  in  DATA_W  write data.
- m0_be  in  DATA_W/8  byte enables; bit i covers byte i.
- m0_gnt  out  1  transfer accepted this cycle (combinational).
- m0_rvalid  out  1  read data valid (registered).
- m0_rdata  out  DATA_W  read data (registered).
- m1_*  same set as m0_*, for port 1.
- ram_addr  out  ADDR_W  RAM address.
- ram_d  out  DATA_W  RAM write data.
- ram_we  out  1  RAM write enable.
- ram_q  in  DATA_W  RAM combinational read data.

Behaviour:
- Transfer rules:
  - A transfer occurs on a cycle where mX_req & mX_gnt.
  - At most one gnt is high per cycle.
  - gnt is never high without req.
  - There is no bubble: if any req is high, exactly one gnt is high.
- State register: IDLE, LOCK0, LOCK1. Registers: last (last granted port), cnt (0..MAX_BURST).
- IDLE:
  - The winner is the requesting port. If both ports request, the winner is the port != last.
  - Granting port X with mX_lock=1 moves to LOCKX with cnt=1.
  - Granting port X with mX_lock=0 stays in IDLE.
  - last <= X on every grant.
- LOCKX, owner keeps the grant:
  - Condition: mX_req=1, and either cnt<MAX_BURST or the other port is idle.
  - On grant: cnt <= min(cnt+1, MAX_BURST).
  - If the granted mX_lock=0, go to IDLE; otherwise stay in LOCKX.
- LOCKX, owner loses the grant:
  - Condition: mX_req=0, or cnt==MAX_BURST with the other port requesting.
  - Arbitrate as in IDLE that same cycle, with last treated as X; the other port wins if it is requesting.
  - Next state follows the IDLE rules for the new winner; cnt reloads to 1 if that winner is locked.
  - If nobody requests, go to IDLE with cnt=0.
- RAM drive:
  - ram_addr = the granted port's address; when there is no grant, ram_addr = m0_addr.
  - ram_we = grant & we & |be.
  - ram_d byte i = be[i] ? wdata byte i : ram_q byte i. This is a same-cycle merge; a full-word write with be = all ones ignores ram_q.
  - A write with be=0 is granted and completes, but does not pulse ram_we.
- Read return:
  - On a granted read, mX_rvalid=1 in the next cycle and mX_rdata = ram_q sampled at the grant edge.
  - rdata holds its value until the next read to that port.
  - rvalid is a one-cycle pulse per read.
  - Back-to-back reads produce back-to-back rvalid pulses.
  - Writes never assert rvalid.
- Simultaneous read by port 0 and write by port 1 to the same address: only one is granted, so this is serialised; a read after a write returns the new data.
- Reset (asynchronous assert, synchronous release):
  - state=IDLE, last=1 (port 0 wins first contention), cnt=0.
  - m0/m1_rvalid=0, m0/m1_rdata=0.
  - gnt and ram_we are forced to 0 while rst_n=0.
  - An in-flight rvalid is dropped.
  - A lock is abandoned.

Decomposition:
- Package dmem_arb_pkg holds:
  - the state enum: IDLE, LOCK0, LOCK1;
  - the constant BE_W = DATA_W/8;
  - a byte-merge function.
- One natural sub-module, rr_pick2: a combinational 2-way round-robin picker with inputs req[1:0] and last, and output one-hot gnt[1:0]. The FSM is wrapped around it.

Test Plan:
- Single port 0 read of addr 5 holding 0xDEADBEEF -> m0_gnt same cycle; next cycle m0_rvalid=1, m0_rdata=0xDEADBEEF; m1_rvalid stays 0.
- Both ports request reads every cycle, lock=0 -> gnt alternates 0,1,0,1 starting with port 0 after reset; no idle cycle.
- Port 0 writes 0xAABBCCDD to addr 3, then port 0 writes 0x00001122 with be=0b0011 -> ram_we pulses twice; read of addr 3 returns 0xAABB1122. A write with be=0 leaves the word at 0xAABB1122 and ram_we=0.
- MAX_BURST=4, m0_lock=1 with continuous req, m1_req high from cycle 1 -> m0 granted 4 consecutive times, then m1 granted once, then m0 again.
- Port 1 locks and drops req after 2 grants while port 0 requests -> m0_gnt in the same cycle m1_req falls; no bubble.
- rst_n pulled low mid-burst with a read pending -> rvalid, gnt and ram_we are 0 immediately; after release, state is IDLE and port 0 wins the first contention.
